mem_arbiter: RTL and testbench

Arbitrates single-port access to the shared instruction/data memory among three requesters: a program loader, the instruction fetch unit and the data load/store unit. It sits directly in front of the memory and is the only driver of the memory's address, write-data and write-select inputs. It serialises requests into one memory access per cycle, routes registered read data back to the owning requester, and rejects out-of-range addresses.

---
 rtl/mem_arbiter_if.sv | 48 ++++
 rtl/mem_arbiter.sv | 122 ++++++++++++
 tb/tb_mem_arbiter.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the three memory requesters, the arbiter and the shared memory.
// Handshake: a requester raises req with addr/wdata (and d_we) and holds them stable until gnt;
// the transfer happens in the cycle where req && gnt, and gnt never depends on a transfer completing.
interface mem_arbiter_if;
  logic        ld_req;
  logic [31:0] ld_addr;
  logic [31:0] ld_wdata;
  logic        ld_gnt;
  logic        ld_err;

  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        if_err;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        d_err;

  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [1:0]  mem_wsel;
  logic [31:0] mem_rdata;
  logic        busy;

  modport slave (
    input  ld_req, ld_addr, ld_wdata, if_req, if_addr,
    input  d_req, d_we, d_addr, d_wdata, mem_rdata,
    output ld_gnt, ld_err, if_gnt, if_rvalid, if_rdata, if_err,
    output d_gnt, d_rvalid, d_rdata, d_err,
    output mem_addr, mem_wdata, mem_wsel, busy
  );

  modport master (
    output ld_req, ld_addr, ld_wdata, if_req, if_addr,
    output d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  ld_gnt, ld_err, if_gnt, if_rvalid, if_rdata, if_err,
    input  d_gnt, d_rvalid, d_rdata, d_err,
    input  mem_addr, mem_wdata, mem_wsel, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: loader > round-robin(fetch, data); two-stage pipeline
// (A drives the memory, B returns registered read data to the owning requester).
module mem_arbiter #(
  parameter int DEPTH = 4096,
  parameter int IDX_W = 12
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {OWN_LD, OWN_IF, OWN_D} owner_t;

  logic        last_d;
  logic        ld_gnt_c, if_gnt_c, d_gnt_c;

  logic        g_valid, g_we;
  owner_t      g_owner;
  logic [31:0] g_addr, g_wdata;

  logic        a_valid, a_we, a_err;
  owner_t      a_owner;
  logic [31:0] a_addr, a_wdata;

  logic        b_valid, b_err;
  owner_t      b_owner;
  logic [31:0] b_rdata;

  logic [1:0]  wsel_c;

  // Both forms agree for power-of-two DEPTH; the compare keeps non-power-of-two depths safe.
  function automatic logic out_of_range(input logic [31:0] a);
    return (|a[31:IDX_W]) || (a >= 32'(DEPTH));
  endfunction

  always_comb begin
    ld_gnt_c = !rst && bus.ld_req;
    if_gnt_c = !rst && !bus.ld_req && bus.if_req && (!bus.d_req || last_d);
    d_gnt_c  = !rst && !bus.ld_req && bus.d_req && (!bus.if_req || !last_d);
  end

  always_comb begin
    g_valid = 1'b0;
    g_we    = 1'b0;
    g_owner = OWN_LD;
    g_addr  = '0;
    g_wdata = '0;
    if (ld_gnt_c) begin
      g_valid = 1'b1;
      g_we    = 1'b1;
      g_owner = OWN_LD;
      g_addr  = bus.ld_addr;
      g_wdata = bus.ld_wdata;
    end else if (if_gnt_c) begin
      g_valid = 1'b1;
      g_owner = OWN_IF;
      g_addr  = bus.if_addr;
    end else if (d_gnt_c) begin
      g_valid = 1'b1;
      g_we    = bus.d_we;
      g_owner = OWN_D;
      g_addr  = bus.d_addr;
      g_wdata = bus.d_we ? bus.d_wdata : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_d  <= 1'b1;
      a_valid <= 1'b0;
      a_we    <= 1'b0;
      a_err   <= 1'b0;
      a_owner <= OWN_LD;
      a_addr  <= '0;
      a_wdata <= '0;
      b_valid <= 1'b0;
      b_err   <= 1'b0;
      b_owner <= OWN_LD;
      b_rdata <= '0;
    end else begin
      if (if_gnt_c)     last_d <= 1'b0;
      else if (d_gnt_c) last_d <= 1'b1;
      a_valid <= g_valid;
      a_we    <= g_we;
      a_err   <= g_valid && out_of_range(g_addr);
      a_owner <= g_owner;
      a_addr  <= g_addr;
      a_wdata <= g_wdata;
      b_valid <= a_valid;
      b_err   <= a_err;
      b_owner <= a_owner;
      b_rdata <= (a_valid && a_owner != OWN_LD && !a_we && !a_err) ? bus.mem_rdata : '0;
    end
  end

  // Gating on rst keeps a stage-A write from committing on the reset edge.
  always_comb begin
    wsel_c = 2'd2;
    if (!rst && a_valid && !a_err) begin
      case (a_owner)
        OWN_LD:  wsel_c = 2'd0;
        OWN_D:   wsel_c = a_we ? 2'd1 : 2'd2;
        default: wsel_c = 2'd2;
      endcase
    end
  end

  assign bus.ld_gnt    = ld_gnt_c;
  assign bus.if_gnt    = if_gnt_c;
  assign bus.d_gnt     = d_gnt_c;
  assign bus.mem_addr  = a_addr;
  assign bus.mem_wdata = a_wdata;
  assign bus.mem_wsel  = wsel_c;
  assign bus.busy      = a_valid || b_valid;

  assign bus.ld_err    = b_valid && (b_owner == OWN_LD) && b_err;
  assign bus.if_rvalid = b_valid && (b_owner == OWN_IF);
  assign bus.if_rdata  = bus.if_rvalid ? b_rdata : '0;
  assign bus.if_err    = bus.if_rvalid && b_err;
  assign bus.d_rvalid  = b_valid && (b_owner == OWN_D);
  assign bus.d_rdata   = bus.d_rvalid ? b_rdata : '0;
  assign bus.d_err     = bus.d_rvalid && b_err;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random held-request traffic, with a
// reference memory and per-port response queues tagged with their due cycle.
module tb_mem_arbiter;
  localparam int DEPTH = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  logic tb_last_d = 1'b1;

  logic [48:0] if_exp_q[$];
  logic [48:0] d_exp_q[$];
  logic [15:0] ld_exp_q[$];

  logic [31:0] mem     [DEPTH];
  logic [31:0] ref_mem [DEPTH];

  // ---------------- clock / reset / DUT ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_arbiter_if bus();

  mem_arbiter #(.DEPTH(DEPTH), .IDX_W(12)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.mem_rdata = mem[bus.mem_addr[11:0]];
  always @(posedge clk) if (bus.mem_wsel != 2'd2) mem[bus.mem_addr[11:0]] <= bus.mem_wdata;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic oor(input logic [31:0] a);
    return a > 32'd4095;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    bus.ld_req = 0; bus.ld_addr = '0; bus.ld_wdata = '0;
    bus.if_req = 0; bus.if_addr = '0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
  endtask

  // One cycle of requests; checks the grant against the bench's arbitration model and
  // pushes the response each granted transfer must produce two cycles later.
  task automatic step(input logic l, input logic [31:0] la, input logic [31:0] lw,
                      input logic f, input logic [31:0] fa,
                      input logic d, input logic dwe, input logic [31:0] da, input logic [31:0] dw,
                      output logic [2:0] eg);
    logic [15:0] due;
    @(negedge clk);
    bus.ld_req = l; bus.ld_addr = la; bus.ld_wdata = lw;
    bus.if_req = f; bus.if_addr = fa;
    bus.d_req = d; bus.d_we = dwe; bus.d_addr = da; bus.d_wdata = dw;
    #1;
    if (l)           eg = 3'b100;
    else if (f && d) eg = tb_last_d ? 3'b010 : 3'b001;
    else             eg = {1'b0, f, d};
    if (eg[1]) tb_last_d = 1'b0;
    if (eg[0]) tb_last_d = 1'b1;
    check("gnt", {bus.ld_gnt, bus.if_gnt, bus.d_gnt}, eg);
    due = 16'(cyc + 2);
    if (eg[2]) begin
      if (oor(la)) ld_exp_q.push_back(due);
      else ref_mem[la[11:0]] = lw;
    end
    if (eg[1]) if_exp_q.push_back({due, oor(fa), oor(fa) ? 32'h0 : ref_mem[fa[11:0]]});
    if (eg[0]) begin
      if (dwe) begin
        if (!oor(da)) ref_mem[da[11:0]] = dw;
        d_exp_q.push_back({due, oor(da), 32'h0});
      end else begin
        d_exp_q.push_back({due, oor(da), oor(da) ? 32'h0 : ref_mem[da[11:0]]});
      end
    end
  endtask

  task automatic idle(input int n);
    logic [2:0] g;
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, g);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    set_idle();
    bus.if_req = 1; bus.d_req = 1; bus.ld_req = 1;
    if_exp_q.delete(); d_exp_q.delete(); ld_exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_gnt", {bus.ld_gnt, bus.if_gnt, bus.d_gnt}, 3'b000);
    check("rst_rvalid", {bus.if_rvalid, bus.d_rvalid, bus.ld_err}, 3'b000);
    check("rst_wsel", bus.mem_wsel, 2'd2);
    check("rst_addr", bus.mem_addr, 32'h0);
    check("rst_busy", bus.busy, 1'b0);
    rst = 1'b0;
    set_idle();
    tb_last_d = 1'b1;
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [48:0] e;
    if (!rst) begin
      if (if_exp_q.size() > 0 && if_exp_q[0][48:33] == cyc[15:0]) begin
        e = if_exp_q.pop_front();
        check("if_rvalid", bus.if_rvalid, 1'b1);
        check("if_err", bus.if_err, e[32]);
        check("if_rdata", bus.if_rdata, e[31:0]);
      end else if (bus.if_rvalid) check("if_rvalid_spurious", bus.if_rvalid, 1'b0);

      if (d_exp_q.size() > 0 && d_exp_q[0][48:33] == cyc[15:0]) begin
        e = d_exp_q.pop_front();
        check("d_rvalid", bus.d_rvalid, 1'b1);
        check("d_err", bus.d_err, e[32]);
        check("d_rdata", bus.d_rdata, e[31:0]);
      end else if (bus.d_rvalid) check("d_rvalid_spurious", bus.d_rvalid, 1'b0);

      if (ld_exp_q.size() > 0 && ld_exp_q[0] == cyc[15:0]) begin
        void'(ld_exp_q.pop_front());
        check("ld_err", bus.ld_err, 1'b1);
      end else if (bus.ld_err) check("ld_err_spurious", bus.ld_err, 1'b0);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [2:0]  g;
    logic        pl, pf, pd, pwe;
    logic [31:0] la, lw, fa, da, dw;

    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = 32'(i) * 32'h9E3779B9;
      ref_mem[i] = 32'(i) * 32'h9E3779B9;
    end
    set_idle();

    reset_dut();
    idle(1);

    // loader write then fetch of the same word
    step(1, 32'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, g);
    step(0, 0, 0, 1, 32'd5, 0, 0, 0, 0, g);
    check("ld_stageA_wsel", bus.mem_wsel, 2'd0);
    check("ld_stageA_addr", bus.mem_addr, 32'd5);
    check("ld_stageA_wdata", bus.mem_wdata, 32'hDEADBEEF);
    idle(3);
    check("busy_drained", bus.busy, 1'b0);

    // round-robin from reset
    reset_dut();
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 1, 32'(200 + i), 1, 0, 32'(100 + i), 0, g);
      check("rr_order", g, (i % 2 == 0) ? 3'b010 : 3'b001);
    end
    idle(3);

    // loader priority, then IF wins the tie, then data
    for (int i = 0; i < 3; i++) step(1, 32'(300 + i), $urandom, 1, 32'd300, 1, 0, 32'd301, 0, g);
    step(0, 0, 0, 1, 32'd300, 1, 0, 32'd301, 0, g);
    check("prio_if_first", g, 3'b010);
    step(0, 0, 0, 0, 0, 1, 0, 32'd301, 0, g);
    idle(3);

    // data write then read of the same word on consecutive grants
    step(0, 0, 0, 0, 0, 1, 1, 32'd50, 32'hCAFEF00D, g);
    step(0, 0, 0, 0, 0, 1, 0, 32'd50, 0, g);
    check("dwr_stageA_wsel", bus.mem_wsel, 2'd1);
    idle(3);

    // range boundaries
    step(0, 0, 0, 0, 0, 1, 1, 32'd4096, 32'h12345678, g);
    step(0, 0, 0, 0, 0, 1, 0, 32'd4095, 0, g);
    check("oor_wsel", bus.mem_wsel, 2'd2);
    check("oor_addr", bus.mem_addr, 32'd4096);
    step(1, 32'h10000, 32'h55AA55AA, 1, 32'hFFFFFFFF, 0, 0, 0, 0, g);
    step(0, 0, 0, 1, 32'hFFFFFFFF, 0, 0, 0, 0, g);
    check("ld_oor_wsel", bus.mem_wsel, 2'd2);
    idle(4);

    // random held-request traffic
    pl = 0; pf = 0; pd = 0; pwe = 0;
    la = 0; lw = 0; fa = 0; da = 0; dw = 0;
    for (int i = 0; i < 400; i++) begin
      if (!pl && $urandom_range(0, 7) == 0) begin
        pl = 1; lw = $urandom;
        la = ($urandom_range(0, 9) == 0) ? 32'h1000 + $urandom_range(0, 255) : 32'($urandom_range(0, 15));
      end
      if (!pf && $urandom_range(0, 2) != 0) begin
        pf = 1;
        fa = ($urandom_range(0, 9) == 0) ? 32'hFFFF_F000 : 32'($urandom_range(0, 15));
      end
      if (!pd && $urandom_range(0, 2) != 0) begin
        pd = 1; pwe = 1'($urandom_range(0, 1)); dw = $urandom;
        da = ($urandom_range(0, 9) == 0) ? 32'd4096 : 32'($urandom_range(0, 15));
      end
      step(pl, la, lw, pf, fa, pd, pwe, da, dw, g);
      if (g[2]) pl = 0;
      if (g[1]) pf = 0;
      if (g[0]) pd = 0;
    end
    idle(4);

    // reset while a data read is in stage A
    step(0, 0, 0, 0, 0, 1, 0, 32'd7, 0, g);
    @(negedge clk);
    rst = 1'b1;
    set_idle();
    bus.d_req = 1; bus.d_addr = 32'd8;
    if_exp_q.delete(); d_exp_q.delete(); ld_exp_q.delete();
    #1;
    check("midrst_gnt", bus.d_gnt, 1'b0);
    @(negedge clk);
    #1;
    check("midrst_rvalid", bus.d_rvalid, 1'b0);
    check("midrst_busy", bus.busy, 1'b0);
    check("midrst_wsel", bus.mem_wsel, 2'd2);
    rst = 1'b0;
    set_idle();
    tb_last_d = 1'b1;
    idle(3);
    step(0, 0, 0, 1, 32'd7, 1, 0, 32'd8, 0, g);
    check("post_rst_tie_if", g, 3'b010);
    idle(4);

    check("if_q_empty", if_exp_q.size(), 0);
    check("d_q_empty", d_exp_q.size(), 0);
    check("ld_q_empty", ld_exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
